// File: rtl/ps2_keyboard_rx_if.sv
// PS/2 receiver line/event bundle: raw keyboard clock/data in, key event and frame error out.
// Latency: none (wiring only).
// Backpressure: none; key events are toggle-strobed and frame errors are single-cycle pulses.
// Ports: ps2_clk, ps2_data (raw lines toward the receiver), ps2_key[10:0] (event), frame_err (pulse).
// The receiver uses the slave modport; whatever drives the lines uses the master modport.
interface ps2_keyboard_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        frame_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  ps2_key,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output ps2_key,
    output frame_err
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 set-2 keyboard receiver: deserialises frames and publishes toggle-strobed key events.
// Latency: event 1 clk after the filtered stop-bit fall (2 clk + FILTER_LEN ce_11m after the line edge).
// Backpressure: none; consumer watches ps2_key[10] for a change, events are >= one PS/2 frame apart.
// Ports: clk, reset_n (async active-low), ce_11m (sample enable),
//        ps2_if.slave: ps2_clk/ps2_data in, ps2_key[10:0] / frame_err out.
// Option: define PS2_TYPEMATIC_FILTER_EN to suppress repeated makes of a key already held.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 2048
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_11m,
  ps2_keyboard_rx_if.slave  ps2_if
);

  localparam logic [3:0]  FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [11:0] TO_LAST   = 12'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Two-flop synchronisers for the asynchronous PS/2 lines.
  logic r_clk_s1, r_clk_s2;
  logic r_dat_s1, r_dat_s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_if.ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_if.ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Glitch filter: the filtered level only follows the line after FILTER_LEN
  // consecutive differing samples; any agreeing sample restarts the count.
  logic       r_filt_clk;
  logic [3:0] r_filt_cnt;
  logic       w_diff;
  logic       w_flip;
  logic       w_fall;

  assign w_diff = (r_clk_s2 != r_filt_clk);
  assign w_flip = ce_11m && w_diff && (r_filt_cnt == FILT_LAST);
  assign w_fall = w_flip && r_filt_clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_filt_clk <= 1'b1;
      r_filt_cnt <= 4'd0;
    end else if (ce_11m) begin
      if (!w_diff) begin
        r_filt_cnt <= 4'd0;
      end else if (r_filt_cnt == FILT_LAST) begin
        r_filt_clk <= ~r_filt_clk;
        r_filt_cnt <= 4'd0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 4'd1;
      end
    end
  end

  // Frame FSM and byte interpretation.
  state_t      r_state;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic        r_par_ok;
  logic [11:0] r_to_cnt;
  logic        r_ext;
  logic        r_brk;
  logic [2:0]  r_skip;
  logic [10:0] r_key;
  logic        r_frame_err;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [511:0] r_held;
  logic [8:0]   w_held_idx;
  assign w_held_idx = {r_ext, r_shift};
`endif

  // Controller chatter that never forms a key when no prefix is pending.
  logic w_is_noise;
  assign w_is_noise = (r_shift == 8'hAA) || (r_shift == 8'hFA) || (r_shift == 8'hEE) ||
                      (r_shift == 8'hFE) || (r_shift == 8'h00) || (r_shift == 8'hFF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_shift     <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_par_ok    <= 1'b0;
      r_to_cnt    <= 12'd0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_skip      <= 3'd0;
      r_key       <= 11'h000;
      r_frame_err <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      r_held      <= '0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      if (r_state == S_IDLE) begin
        r_to_cnt <= 12'd0;
        if (w_fall && !r_dat_s2) begin
          r_state   <= S_DATA;
          r_bit_cnt <= 3'd0;
        end
      end else if (w_fall) begin
        // A fall in the same tick as timeout expiry takes priority.
        r_to_cnt <= 12'd0;
        case (r_state)
          S_DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_PARITY;
            end
          end
          S_PARITY: begin
            r_par_ok <= ^{r_shift, r_dat_s2};
            r_state  <= S_STOP;
          end
          default: begin
            r_state <= S_IDLE;
            if (r_dat_s2 && r_par_ok) begin
              if (r_skip != 3'd0) begin
                r_skip <= r_skip - 3'd1;
              end else if (r_shift == 8'hE0) begin
                r_ext <= 1'b1;
              end else if (r_shift == 8'hF0) begin
                r_brk <= 1'b1;
              end else if (r_shift == 8'hE1) begin
                // Pause: swallow the remaining 7 bytes of the sequence.
                r_skip <= 3'd7;
              end else if (!(w_is_noise && !r_ext && !r_brk)) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                if (r_brk) begin
                  r_held[w_held_idx] <= 1'b0;
                  r_key <= {~r_key[10], ~r_brk, r_ext, r_shift};
                end else if (!r_held[w_held_idx]) begin
                  r_held[w_held_idx] <= 1'b1;
                  r_key <= {~r_key[10], ~r_brk, r_ext, r_shift};
                end
`else
                r_key <= {~r_key[10], ~r_brk, r_ext, r_shift};
`endif
                r_ext <= 1'b0;
                r_brk <= 1'b0;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_ext       <= 1'b0;
              r_brk       <= 1'b0;
              r_skip      <= 3'd0;
            end
          end
        endcase
      end else if (ce_11m) begin
        if (r_to_cnt == TO_LAST) begin
          r_frame_err <= 1'b1;
          r_state     <= S_IDLE;
          r_to_cnt    <= 12'd0;
          r_ext       <= 1'b0;
          r_brk       <= 1'b0;
          r_skip      <= 3'd0;
        end else begin
          r_to_cnt <= r_to_cnt + 12'd1;
        end
      end
    end
  end

  assign ps2_if.ps2_key   = r_key;
  assign ps2_if.frame_err = r_frame_err;

endmodule
